// File: rtl/mmio_host_initiator.sv
// Host-side MMIO initiator for CCI-P style AFU MMIO ports.
// Issues read/write requests, tracks reads by tid, returns data with address.
module mmio_host_initiator #(
  parameter int TID_WIDTH       = 9,
  parameter int MAX_OUTSTANDING = 8,
  parameter int TIMEOUT_CYCLES  = 512
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_wr,
  input  logic                 cmd_is64,
  input  logic [15:0]          cmd_addr,
  input  logic [63:0]          cmd_wdata,
  output logic                 mmio_wr_valid,
  output logic                 mmio_rd_valid,
  output logic [15:0]          mmio_addr,
  output logic [1:0]           mmio_length,
  output logic [TID_WIDTH-1:0] mmio_tid,
  output logic [63:0]          mmio_wdata,
  input  logic                 afu_rd_valid,
  input  logic [TID_WIDTH-1:0] afu_tid,
  input  logic [63:0]          afu_data,
  output logic                 rsp_valid,
  output logic [TID_WIDTH-1:0] rsp_tid,
  output logic [15:0]          rsp_addr,
  output logic [63:0]          rsp_data,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
  output logic                 err_unexpected,
  output logic                 err_timeout,
  input  logic                 err_clr
);

  localparam int IW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [MAX_OUTSTANDING-1:0] pending;
  logic [MAX_OUTSTANDING-1:0] pend_set;
  logic [MAX_OUTSTANDING-1:0] pend_clr;
  logic [IW-1:0]              next_tid;
  logic [IW-1:0]              idx;
  logic [WW-1:0]              wd;
  logic [15:0]                tbl_addr [MAX_OUTSTANDING];
  logic                       tbl_is64 [MAX_OUTSTANDING];
  logic                       acc;
  logic                       issue_rd;
  logic                       tid_ok;
  logic                       hit;
  logic                       stall;
  logic                       tmo;
  logic [15:0]                req_addr;

  assign cmd_ready = !err_timeout &&
    (cmd_wr || (outstanding < OW'(MAX_OUTSTANDING) && !pending[next_tid]));

  always_comb begin
    acc      = cmd_valid && cmd_ready;
    issue_rd = acc && !cmd_wr;
    idx      = afu_tid[IW-1:0];
    tid_ok   = afu_tid < TID_WIDTH'(MAX_OUTSTANDING);
    hit      = afu_rd_valid && tid_ok && pending[idx];
    stall    = (outstanding != '0) && !hit;
    tmo      = stall && (wd == WW'(TIMEOUT_CYCLES - 2));
    req_addr = cmd_is64 ? {cmd_addr[15:1], 1'b0} : cmd_addr;
    pend_set = '0;
    pend_clr = '0;
    if (issue_rd) pend_set = MAX_OUTSTANDING'(1) << next_tid;
    if (hit)      pend_clr = MAX_OUTSTANDING'(1) << idx;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mmio_wr_valid  <= 1'b0;
      mmio_rd_valid  <= 1'b0;
      mmio_addr      <= '0;
      mmio_length    <= '0;
      mmio_tid       <= '0;
      mmio_wdata     <= '0;
      rsp_valid      <= 1'b0;
      rsp_tid        <= '0;
      rsp_addr       <= '0;
      rsp_data       <= '0;
      outstanding    <= '0;
      err_unexpected <= 1'b0;
      err_timeout    <= 1'b0;
      pending        <= '0;
      next_tid       <= '0;
      wd             <= '0;
    end else begin
      mmio_wr_valid <= acc && cmd_wr;
      mmio_rd_valid <= issue_rd;
      if (acc) begin
        mmio_addr   <= req_addr;
        mmio_length <= {1'b0, cmd_is64};
        mmio_tid    <= TID_WIDTH'(next_tid);
        mmio_wdata  <= cmd_wdata;
      end
      if (issue_rd) next_tid <= next_tid + IW'(1);
      rsp_valid <= hit;
      if (hit) begin
        rsp_tid  <= afu_tid;
        rsp_addr <= tbl_addr[idx];
        rsp_data <= tbl_is64[idx] ? afu_data : {32'h0, afu_data[31:0]};
      end
      // A timeout discards everything in flight, including a same-cycle issue
      if (tmo) begin
        pending     <= '0;
        outstanding <= '0;
        wd          <= '0;
      end else begin
        pending     <= (pending | pend_set) & ~pend_clr;
        outstanding <= outstanding + OW'(issue_rd) - OW'(hit);
        wd          <= stall ? wd + WW'(1) : '0;
      end
      if (afu_rd_valid && !hit) err_unexpected <= 1'b1;
      else if (err_clr)         err_unexpected <= 1'b0;
      if (tmo)          err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (issue_rd) begin
      tbl_addr[next_tid] <= req_addr;
      tbl_is64[next_tid] <= cmd_is64;
    end
  end

endmodule

// File: tb/tb_mmio_host_initiator.sv
// Bench for mmio_host_initiator: per-cycle model compare
// plus directed scenarios with literal expectations.
module tb_mmio_host_initiator;

  localparam int TW = 9;
  localparam int MO = 8;
  localparam int TC = 512;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 0, cmd_wr = 0, cmd_is64 = 0;
  logic          cmd_ready;
  logic [15:0]   cmd_addr = '0;
  logic [63:0]   cmd_wdata = '0;
  logic          mmio_wr_valid, mmio_rd_valid;
  logic [15:0]   mmio_addr;
  logic [1:0]    mmio_length;
  logic [TW-1:0] mmio_tid;
  logic [63:0]   mmio_wdata;
  logic          afu_rd_valid = 0;
  logic [TW-1:0] afu_tid = '0;
  logic [63:0]   afu_data = '0;
  logic          rsp_valid;
  logic [TW-1:0] rsp_tid;
  logic [15:0]   rsp_addr;
  logic [63:0]   rsp_data;
  logic [3:0]    outstanding;
  logic          err_unexpected, err_timeout;
  logic          err_clr = 0;

  int checks = 0;
  int errors = 0;

  mmio_host_initiator #(
    .TID_WIDTH(TW), .MAX_OUTSTANDING(MO), .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_wr(cmd_wr), .cmd_is64(cmd_is64),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mmio_wr_valid(mmio_wr_valid), .mmio_rd_valid(mmio_rd_valid),
    .mmio_addr(mmio_addr), .mmio_length(mmio_length),
    .mmio_tid(mmio_tid), .mmio_wdata(mmio_wdata),
    .afu_rd_valid(afu_rd_valid), .afu_tid(afu_tid), .afu_data(afu_data),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid),
    .rsp_addr(rsp_addr), .rsp_data(rsp_data),
    .outstanding(outstanding),
    .err_unexpected(err_unexpected), .err_timeout(err_timeout),
    .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: a set of pending reads, each remembering its address/size
  bit          m_pend [MO];
  logic [15:0] m_addr [MO];
  bit          m_is64 [MO];
  int          m_next, m_wait;
  bit          m_eu, m_et;
  bit          e_wr, e_rd, e_rsp, e_w64;
  logic [15:0] e_maddr, e_raddr;
  logic [1:0]  e_len;
  int          e_mtid, e_rtid;
  logic [63:0] e_wd, e_rdata;

  function automatic int pend_cnt();
    int n = 0;
    for (int i = 0; i < MO; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < MO; i++) m_pend[i] = 0;
        m_next = 0; m_wait = 0; m_eu = 0; m_et = 0;
        e_wr = 0; e_rd = 0; e_rsp = 0;
      end else begin
        int  cnt, t;
        bit  rdy, acc, tmo;
        cnt = pend_cnt();
        rdy = !m_et && (cmd_wr || (cnt < MO && !m_pend[m_next]));
        acc = cmd_valid && rdy;
        e_wr = acc && cmd_wr;
        e_rd = acc && !cmd_wr;
        if (acc) begin
          e_maddr = cmd_is64 ? (cmd_addr & 16'hFFFE) : cmd_addr;
          e_len   = cmd_is64 ? 2'b01 : 2'b00;
          e_mtid  = m_next;
          e_wd    = cmd_wdata;
          e_w64   = cmd_is64;
        end
        t = int'(afu_tid);
        e_rsp = afu_rd_valid && t < MO && m_pend[t % MO];
        if (e_rsp) begin
          e_rtid  = t;
          e_raddr = m_addr[t];
          e_rdata = m_is64[t] ? afu_data : (afu_data & 64'hFFFF_FFFF);
          m_pend[t] = 0;
        end
        if (afu_rd_valid && !e_rsp) m_eu = 1;
        else if (err_clr) m_eu = 0;
        tmo = 0;
        if (cnt == 0 || e_rsp) m_wait = 0;
        else begin
          m_wait++;
          if (m_wait == TC - 1) tmo = 1;
        end
        if (e_rd) begin
          m_pend[m_next] = 1;
          m_addr[m_next] = e_maddr;
          m_is64[m_next] = cmd_is64;
          m_next = (m_next + 1) % MO;
        end
        if (tmo) begin
          for (int i = 0; i < MO; i++) m_pend[i] = 0;
          m_et = 1;
          m_wait = 0;
        end else if (err_clr) m_et = 0;
      end
      #1;
      chk("mmio_wr_valid", 64'(mmio_wr_valid), 64'(e_wr));
      chk("mmio_rd_valid", 64'(mmio_rd_valid), 64'(e_rd));
      if (e_wr || e_rd) begin
        chk("mmio_addr", 64'(mmio_addr), 64'(e_maddr));
        chk("mmio_length", 64'(mmio_length), 64'(e_len));
        chk("mmio_tid", 64'(mmio_tid), 64'(e_mtid));
      end
      if (e_wr)
        chk("mmio_wdata", e_w64 ? mmio_wdata : 64'(mmio_wdata[31:0]),
            e_w64 ? e_wd : 64'(e_wd[31:0]));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_rsp));
      if (e_rsp) begin
        chk("rsp_tid", 64'(rsp_tid), 64'(e_rtid));
        chk("rsp_addr", 64'(rsp_addr), 64'(e_raddr));
        chk("rsp_data", rsp_data, e_rdata);
      end
      chk("outstanding", 64'(outstanding), 64'(pend_cnt()));
      chk("err_unexpected", 64'(err_unexpected), 64'(m_eu));
      chk("err_timeout", 64'(err_timeout), 64'(m_et));
      if (!rst)
        chk("cmd_ready", 64'(cmd_ready), 64'(!m_et &&
            (cmd_wr || (pend_cnt() < MO && !m_pend[m_next]))));
    end
  end

  task automatic issue(input bit wr, input bit is64,
                       input logic [15:0] a, input logic [63:0] d);
    @(negedge clk);
    cmd_valid = 1; cmd_wr = wr; cmd_is64 = is64;
    cmd_addr = a; cmd_wdata = d;
    @(negedge clk);
    cmd_valid = 0; cmd_wr = 0; cmd_is64 = 0;
  endtask

  task automatic respond(input logic [TW-1:0] t, input logic [63:0] d);
    @(negedge clk);
    afu_rd_valid = 1; afu_tid = t; afu_data = d;
    @(negedge clk);
    afu_rd_valid = 0;
  endtask

  task automatic clear_errs();
    @(negedge clk);
    err_clr = 1;
    @(negedge clk);
    err_clr = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst outstanding", 64'(outstanding), 64'd0);
    chk("rst err_unexpected", 64'(err_unexpected), 64'd0);
    chk("rst err_timeout", 64'(err_timeout), 64'd0);
    chk("rst mmio_rd_valid", 64'(mmio_rd_valid), 64'd0);
    rst = 0;

    issue(1, 1, 16'h0020, 64'hDEAD_BEEF_0123_4567);
    chk("wr pulse", 64'(mmio_wr_valid), 64'd1);
    chk("wr length", 64'(mmio_length), 64'd1);
    chk("wr addr", 64'(mmio_addr), 64'h20);
    chk("wr data", mmio_wdata, 64'hDEAD_BEEF_0123_4567);
    @(negedge clk);
    chk("wr pulse end", 64'(mmio_wr_valid), 64'd0);

    issue(0, 0, 16'h0022, 64'd0);
    chk("rd pulse", 64'(mmio_rd_valid), 64'd1);
    chk("rd tid", 64'(mmio_tid), 64'd0);
    repeat (2) @(negedge clk);
    respond(0, 64'hFFFF_FFFF_AAAA_5555);
    chk("rd rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd rsp_addr", 64'(rsp_addr), 64'h22);
    chk("rd rsp_data", rsp_data, 64'h0000_0000_AAAA_5555);

    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    for (int i = 0; i < 8; i++) begin
      issue(0, i[0], 16'h0100 + 16'(2 * i), 64'd0);
      chk("burst tid", 64'(mmio_tid), 64'(i));
    end
    chk("full outstanding", 64'(outstanding), 64'd8);
    cmd_valid = 1; cmd_wr = 0;
    #1 chk("full rd ready", 64'(cmd_ready), 64'd0);
    cmd_wr = 1;
    #1 chk("full wr ready", 64'(cmd_ready), 64'd1);
    cmd_valid = 0; cmd_wr = 0;
    respond(5, 64'h5555_0000_0000_0005);
    chk("t5 tid", 64'(rsp_tid), 64'd5);
    chk("t5 addr", 64'(rsp_addr), 64'h10A);
    chk("t5 data", rsp_data, 64'h5555_0000_0000_0005);
    respond(2, 64'h2222_0000_0000_0002);
    chk("t2 tid", 64'(rsp_tid), 64'd2);
    chk("t2 data", rsp_data, 64'h0000_0000_0000_0002);
    chk("after 5,2", 64'(outstanding), 64'd6);
    for (int i = 0; i < 8; i++)
      if (i != 5 && i != 2) respond(TW'(i), 64'(i));
    chk("drained", 64'(outstanding), 64'd0);

    respond(3, 64'h33);
    chk("unexp flag", 64'(err_unexpected), 64'd1);
    chk("unexp no rsp", 64'(rsp_valid), 64'd0);
    clear_errs();
    chk("unexp cleared", 64'(err_unexpected), 64'd0);
    @(negedge clk);
    afu_rd_valid = 1; afu_tid = 9'h10B; err_clr = 1;
    @(negedge clk);
    afu_rd_valid = 0; err_clr = 0;
    chk("err beats clr", 64'(err_unexpected), 64'd1);
    clear_errs();

    issue(0, 0, 16'h0040, 64'd0);
    repeat (510) @(negedge clk);
    chk("pre timeout", 64'(err_timeout), 64'd0);
    chk("pre timeout outst", 64'(outstanding), 64'd1);
    @(negedge clk);
    chk("timeout", 64'(err_timeout), 64'd1);
    chk("timeout outst", 64'(outstanding), 64'd0);
    chk("timeout ready", 64'(cmd_ready), 64'd0);
    respond(0, 64'h1);
    chk("late rsp", 64'(err_unexpected), 64'd1);
    clear_errs();
    chk("timeout cleared", 64'(err_timeout), 64'd0);

    issue(0, 1, 16'h0044, 64'd0);
    repeat (509) @(negedge clk);
    respond(1, 64'hCAFE_F00D_1234_5678);
    chk("edge rsp_valid", 64'(rsp_valid), 64'd1);
    chk("edge rsp_tid", 64'(rsp_tid), 64'd1);
    chk("edge rsp_data", rsp_data, 64'hCAFE_F00D_1234_5678);
    chk("edge no timeout", 64'(err_timeout), 64'd0);

    for (int i = 0; i < 4; i++) issue(0, 0, 16'h0080 + 16'(i), 64'd0);
    chk("four pending", 64'(outstanding), 64'd4);
    @(negedge clk); rst = 1;
    #1 chk("async rst outst", 64'(outstanding), 64'd0);
    @(negedge clk); rst = 0;
    respond(2, 64'h2);
    chk("post rst unexp", 64'(err_unexpected), 64'd1);
    chk("post rst no rsp", 64'(rsp_valid), 64'd0);
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
